pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage MIPS pipeline. Works with the operand-forwarding logic.

---
 rtl/pipeline_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, multi-cycle
// mul/div freeze, taken-branch flush, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_md_start,
    input  logic             Branch_taken,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    state_t     state, state_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    logic       load_use;

    always_comb begin
        load_use = ID_EX_MemRead && (ID_EX_rt != '0) &&
                   ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
    end

    // Outputs are gated by rst_n so they sit at defaults while reset is held.
    always_comb begin
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ID_EX_md_start) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        md_cnt_nxt   = MD_LOAD;
                        state_nxt    = MD_BUSY;
                    end else if (Branch_taken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy      = 1'b1;
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    md_cnt_nxt   = md_cnt - 8'd1;
                    if (md_cnt == 8'd1) begin
                        md_done   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!PC_Write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic       ID_EX_MemRead, ID_EX_md_start, Branch_taken;

    logic        PC_Write, IF_ID_Write, ID_EX_Write;
    logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_busy, md_done;
    logic [15:0] stall_cycles;

    logic        s_PC_Write, s_IF_ID_Write, s_ID_EX_Write;
    logic        s_IF_ID_Flush, s_ID_EX_Flush, s_EX_MEM_Flush, s_md_busy, s_md_done;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_md_start(ID_EX_md_start),
        .Branch_taken(Branch_taken),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Flush(EX_MEM_Flush), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_md_start(ID_EX_md_start),
        .Branch_taken(Branch_taken),
        .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .ID_EX_Write(s_ID_EX_Write),
        .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Flush(s_ID_EX_Flush),
        .EX_MEM_Flush(s_EX_MEM_Flush), .md_busy(s_md_busy), .md_done(s_md_done),
        .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                          input logic mr, input logic md, input logic br);
        IF_ID_rs       = rs;
        IF_ID_rt       = rt;
        ID_EX_rt       = ex_rt;
        ID_EX_MemRead  = mr;
        ID_EX_md_start = md;
        Branch_taken   = br;
        #1;
    endtask

    // Packed {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_busy, md_done}
    function automatic logic [7:0] ctl();
        return {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush,
                ID_EX_Flush, EX_MEM_Flush, md_busy, md_done};
    endfunction

    initial begin
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_ctl", 32'(ctl()), 32'b1110_0000);
        chk("reset_cnt", 32'(stall_cycles), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load-use on rt
        set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("lu_rt_ctl", 32'(ctl()), 32'b0010_1000);
        tick();
        set_in(5'd3, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble_ctl", 32'(ctl()), 32'b1110_0000);
        chk("lu_cnt", 32'(stall_cycles), 32'd1);

        // ID_EX_rt = 0 never stalls, even when all registers match
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("lu_r0_ctl", 32'(ctl()), 32'b1110_0000);
        tick();
        chk("lu_r0_cnt", 32'(stall_cycles), 32'd1);

        // Load-use on rs
        set_in(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("lu_rs_ctl", 32'(ctl()), 32'b0010_1000);
        tick();
        set_in(5'd7, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lu_nomatch_ctl", 32'(ctl()), 32'b1110_0000);
        tick();
        chk("lu_rs_cnt", 32'(stall_cycles), 32'd2);

        // Mul/div freeze, issue cycle T
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("md_T", 32'(ctl()), 32'b0000_0100);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("md_T1", 32'(ctl()), 32'b0000_0110);
        tick();
        chk("md_T2", 32'(ctl()), 32'b0000_0110);
        tick();
        chk("md_T3", 32'(ctl()), 32'b0000_0111);
        tick();
        chk("md_T4", 32'(ctl()), 32'b1110_0000);
        chk("md_cnt", 32'(stall_cycles), 32'd6);

        // Branch suppresses load-use
        set_in(5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
        chk("br_lu_ctl", 32'(ctl()), 32'b1111_1000);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("br_lu_cnt", 32'(stall_cycles), 32'd6);

        // md_start wins over branch; branch ignored while busy
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("prec_T", 32'(ctl()), 32'b0000_0100);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("prec_T1", 32'(ctl()), 32'b0000_0110);
        tick();
        chk("prec_T2", 32'(ctl()), 32'b0000_0110);
        tick();
        chk("prec_T3", 32'(ctl()), 32'b0000_0111);
        tick();
        chk("prec_T4", 32'(ctl()), 32'b1111_1000);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("prec_cnt", 32'(stall_cycles), 32'd10);

        // Async reset mid-MD_BUSY with load-use inputs active
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_busy", 32'(md_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 32'(ctl()), 32'b1110_0000);
        chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_async_cnt_sat", 32'(s_stall_cycles), 32'd0);
        tick();
        chk("rst_held_ctl", 32'(ctl()), 32'b1110_0000);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_run_ctl", 32'(ctl()), 32'b1110_0000);
        tick();
        chk("rst_no_done", 32'(md_done), 32'd0);
        chk("rst_cnt_after", 32'(stall_cycles), 32'd0);

        // Saturation: hold load-use for 20 cycles
        set_in(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        repeat (14) tick();
        chk("sat_14", 32'(s_stall_cycles), 32'd14);
        tick();
        chk("sat_15", 32'(s_stall_cycles), 32'd15);
        repeat (5) tick();
        chk("sat_hold", 32'(s_stall_cycles), 32'd15);
        chk("wide_20", 32'(stall_cycles), 32'd20);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sat_idle", 32'(s_stall_cycles), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
